// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: op codes, FSM states and
// small op-decode helpers.
package jk_pkg;

    typedef logic [1:0] jk_op_t;

    localparam jk_op_t OP_HOLD   = 2'b00;
    localparam jk_op_t OP_RESET  = 2'b01;
    localparam jk_op_t OP_SET    = 2'b10;
    localparam jk_op_t OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_RESP  = 2'd2
    } jk_state_t;

    // The op code is laid out so that bit 1 is J and bit 0 is K.
    function automatic logic op_j(input jk_op_t op);
        return op[1];
    endfunction

    function automatic logic op_k(input jk_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found when
// searching upward from last_i+1, wrapping around. Nothing is granted
// while en_i is low.
module jk_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    // Priority search starting just after the previous winner.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = int'(last_i) + i;
            if (c >= NREQ) c = c - NREQ;
            if (en_i && !any_o && req_i[c]) begin
                any_o      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Shares one bank of JK flip-flops between several command sources.
// One command is granted at a time, applied for a single cycle, and the
// resulting bank value is returned on a valid/ready response.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a command; grant and latch it in the same cycle
//   S_APPLY | drive j/k from the latched op/mask; bank updates at cycle end
//   S_RESP  | present rsp_id/rsp_q until the consumer takes them
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_q,
    output logic [WIDTH-1:0]      q
);

    jk_state_t        state_q, state_d;
    logic [IDW-1:0]   last_q,  last_d;
    logic [IDW-1:0]   gid_q,   gid_d;
    jk_op_t           op_q,    op_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] bank_q,  bank_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH-1:0] j_vec, k_vec;
    logic [NREQ-1:0]  grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             arb_en;

    // Gating with rst keeps req_ready low while reset is held even though
    // the FSM already sits in S_IDLE.
    assign arb_en = (state_q == S_IDLE) && rst;

    jk_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (req_valid),
        .last_i  (last_q),
        .en_i    (arb_en),
        .grant_o (grant_oh),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Next-state, bank update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gid_d     = gid_q;
        op_d      = op_q;
        mask_d    = mask_q;
        bank_d    = bank_q;
        rdata_d   = rdata_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        j_vec     = '0;
        k_vec     = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    req_ready = grant_oh;
                    gid_d     = grant_idx;
                    last_d    = grant_idx;
                    op_d      = req_op[2*int'(grant_idx) +: 2];
                    mask_d    = req_mask[WIDTH*int'(grant_idx) +: WIDTH];
                    state_d   = S_APPLY;
                end
            end
            S_APPLY: begin
                j_vec   = {WIDTH{op_j(op_q)}} & mask_q;
                k_vec   = {WIDTH{op_k(op_q)}} & mask_q;
                bank_d  = (j_vec & ~bank_q) | (~k_vec & bank_q);
                rdata_d = bank_d;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(NREQ - 1);
            gid_q   <= '0;
            op_q    <= OP_HOLD;
            mask_q  <= '0;
            bank_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            bank_q  <= bank_d;
            rdata_q <= rdata_d;
        end
    end

    assign rsp_id = gid_q;
    assign rsp_q  = rdata_q;
    assign q      = bank_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with NREQ=2, WIDTH=8.
module tb_jk_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [7:0]  rsp_q;
    logic [7:0]  q;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_bank;

    jk_bank_arbiter #(.NREQ(2), .WIDTH(8), .IDW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_mask  (req_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .q         (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [3:0]  op;
        logic [15:0] mask;
        logic [1:0]  ready;
        logic        id;
        logic [7:0]  rq;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full command with rsp_ready high; entered and left at #1 after posedge in IDLE.
    task automatic run_cmd(input string tag, input logic [1:0] v, input logic [3:0] op,
                           input logic [15:0] m, input logic [1:0] ex_ready,
                           input logic ex_id, input logic [7:0] ex_q);
        req_valid = v;
        req_op    = op;
        req_mask  = m;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(ex_ready));
        chk({tag, ".idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk({tag, ".apply_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".apply_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".apply_q"}, 32'(q), 32'(exp_bank));
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(ex_id));
        chk({tag, ".rsp_q"}, 32'(rsp_q), 32'(ex_q));
        chk({tag, ".q"}, 32'(q), 32'(ex_q));
        exp_bank = ex_q;
        @(posedge clk); #1;
    endtask

    initial begin
        // valid, {op1,op0}, {m1,m0}, ready, id, rsp_q
        tbl[0] = '{2'b01, 4'b0010, 16'h000F, 2'b01, 1'b0, 8'h0F}; // SET r0
        tbl[1] = '{2'b10, 4'b0000, 16'hFF00, 2'b10, 1'b1, 8'h0F}; // HOLD r1
        tbl[2] = '{2'b11, 4'b0111, 16'h03FF, 2'b01, 1'b0, 8'hF0}; // contention: r0 TOGGLE
        tbl[3] = '{2'b11, 4'b0111, 16'h03FF, 2'b10, 1'b1, 8'hF0}; // then r1 RESET 03
        tbl[4] = '{2'b11, 4'b1001, 16'h01F0, 2'b01, 1'b0, 8'h00}; // r0 RESET F0
        tbl[5] = '{2'b11, 4'b1010, 16'hA5A5, 2'b10, 1'b1, 8'hA5}; // r1 SET A5
        tbl[6] = '{2'b01, 4'b0011, 16'h0000, 2'b01, 1'b0, 8'hA5}; // null TOGGLE
        tbl[7] = '{2'b01, 4'b0011, 16'h00FF, 2'b01, 1'b0, 8'h5A}; // TOGGLE FF
        tbl[8] = '{2'b10, 4'b1100, 16'hFF00, 2'b10, 1'b1, 8'hA5}; // TOGGLE FF via r1
        tbl[9] = '{2'b11, 4'b0010, 16'h0000, 2'b01, 1'b0, 8'hA5}; // SET, zero mask

        // Reset with arbitrary inputs driven.
        rst       = 1'b0;
        req_valid = 2'b11;
        req_op    = 4'b1111;
        req_mask  = 16'hFFFF;
        rsp_ready = 1'b1;
        exp_bank  = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst.q", 32'(q), 32'd0);
            chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst.req_ready", 32'(req_ready), 32'd0);
            chk("rst.rsp_id", 32'(rsp_id), 32'd0);
            chk("rst.rsp_q", 32'(rsp_q), 32'd0);
        end
        req_valid = 2'b00;
        rst       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle.q", 32'(q), 32'd0);
            chk("idle.rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle.req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), tbl[i].valid, tbl[i].op, tbl[i].mask,
                    tbl[i].ready, tbl[i].id, tbl[i].rq);
        end

        // Back-pressure: r0 TOGGLE 0F on A5 -> AA, consumer stalls 3 cycles
        // while r1 waits.
        req_valid = 2'b01;
        req_op    = 4'b0011;
        req_mask  = 16'hFF0F;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp.grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_op    = 4'b0000;
        @(negedge clk);
        chk("bp.apply_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp.rsp_id", 32'(rsp_id), 32'd0);
            chk("bp.rsp_q", 32'(rsp_q), 32'hAA);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
            chk("bp.q", 32'(q), 32'hAA);
        end
        rsp_ready = 1'b1;
        exp_bank  = 8'hAA;
        @(posedge clk); #1;
        chk("bp.after_rsp_valid", 32'(rsp_valid), 32'd0);
        run_cmd("bp.r1", 2'b10, 4'b0000, 16'hFF0F, 2'b10, 1'b1, 8'hAA);

        // Reset asserted during APPLY of SET FF: bank cleared, no response.
        req_valid = 2'b01;
        req_op    = 4'b0010;
        req_mask  = 16'h00FF;
        @(negedge clk);
        chk("mid.grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst       = 1'b0;
        #1;
        chk("mid.q_cleared", 32'(q), 32'd0);
        chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid.no_rsp", 32'(rsp_valid), 32'd0);
            chk("mid.q", 32'(q), 32'd0);
        end
        @(posedge clk); #1;
        exp_bank = 8'h00;
        // Pointer is back to its reset value, so requester 0 wins.
        run_cmd("post_rst", 2'b11, 4'b1010, 16'h3CC3, 2'b01, 1'b0, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
